// File: rtl/ce_gen_pkg.sv
// Shared definitions for the clock-enable generator: state encodings and default width.
package ce_gen_pkg;

  localparam int CE_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    CE_IDLE = 2'd0,
    CE_RUN  = 2'd1,
    CE_SHOT = 2'd2
  } ce_state_e;

endpackage

// File: rtl/ce_gen_dcntr.sv
// Loadable down-counter with zero flag; load has priority over decrement.
module ce_gen_dcntr
  import ce_gen_pkg::*;
#(
  parameter int WIDTH = CE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Decrement is gated at zero so the counter can never wrap.
  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q    = count_q;
  assign zero = (count_q == '0);

endmodule

// File: rtl/ce_gen.sv
// Programmable clock-enable generator: one-cycle ce every N+1 clocks, free-run or one-shot.
module ce_gen
  import ce_gen_pkg::*;
#(
  parameter int WIDTH = CE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_we,
  input  logic [WIDTH-1:0] div_in,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  output logic             ce,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  ce_state_e        state_q;
  ce_state_e        state_d;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] ld_val;
  logic             cnt_ld;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [WIDTH-1:0] cnt_q;

  // A divider write on the same edge as a start or reload takes effect immediately.
  assign ld_val = div_we ? div_in : div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '1;
    end else if (div_we) begin
      div_q <= div_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    if (stop) begin
      state_d = CE_IDLE;
    end else if (start) begin
      cnt_ld  = 1'b1;
      state_d = oneshot ? CE_SHOT : CE_RUN;
    end else begin
      case (state_q)
        CE_IDLE: ;
        CE_RUN: begin
          if (cnt_zero) begin
            cnt_ld = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        CE_SHOT: begin
          if (cnt_zero) begin
            state_d = CE_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = CE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  ce_gen_dcntr #(
    .WIDTH(WIDTH)
  ) u_dcntr (
    .clk   (clk),
    .rst   (rst),
    .ld    (cnt_ld),
    .ld_val(ld_val),
    .dec   (cnt_dec),
    .q     (cnt_q),
    .zero  (cnt_zero)
  );

  // Outputs come straight from registers so ce has no input-to-output path.
  assign busy  = (state_q != CE_IDLE);
  assign ce    = busy && cnt_zero;
  assign count = cnt_q;

endmodule

// File: tb/tb_ce_gen.sv
// Self-checking bench for ce_gen: directed scenarios plus random traffic against a pulse-time model.
module tb_ce_gen;

  logic       clk = 1'b0;
  logic       rst, div_we, start, stop, oneshot;
  logic [7:0] div_in;
  logic       ce, busy;
  logic [7:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: absolute cycle of the next pulse while active, held count while idle.
  int m_c     = 0;
  bit m_active = 0;
  bit m_shot   = 0;
  int m_tnext  = 0;
  int m_hold   = 0;
  int m_div    = 255;
  bit         exp_ce, exp_busy;
  logic [7:0] exp_count;

  ce_gen dut (
    .clk    (clk),
    .rst    (rst),
    .div_we (div_we),
    .div_in (div_in),
    .start  (start),
    .stop   (stop),
    .oneshot(oneshot),
    .ce     (ce),
    .busy   (busy),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit we, input int din, input bit st, input bit sp, input bit os);
    int ld;
    bit pulse;
    rst = r; div_we = we; div_in = din[7:0]; start = st; stop = sp; oneshot = os;
    @(posedge clk);
    pulse = m_active && (m_c == m_tnext);
    ld = we ? din : m_div;
    if (r) begin
      m_active = 0; m_hold = 0; m_div = 255;
    end else begin
      if (sp) begin
        if (m_active) m_hold = m_tnext - m_c;
        m_active = 0;
      end else if (st) begin
        m_active = 1; m_shot = os; m_tnext = m_c + 1 + ld;
      end else if (pulse) begin
        if (m_shot) begin
          m_active = 0; m_hold = 0;
        end else begin
          m_tnext = m_c + 1 + ld;
        end
      end
      if (we) m_div = din;
    end
    m_c++;
    exp_busy  = m_active;
    exp_ce    = m_active && (m_tnext == m_c);
    exp_count = 8'(m_active ? (m_tnext - m_c) : m_hold);
    #1;
  endtask

  task automatic test_reset();
    int n;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({ce, busy, count} !== 10'd0) begin
        n_errors++;
        $display("FAIL reset_idle cyc=%0d got ce=%b busy=%b count=%0d exp 0/0/0", m_c, ce, busy, count);
      end
    end
    step(0, 0, 0, 1, 0, 0);
    n = 1;
    while (ce !== 1'b1 && n < 300) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      n_checks++;
      if ({ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL reset_default_model cyc=%0d got %b/%b/%0d exp %b/%b/%0d", m_c, ce, busy, count, exp_ce, exp_busy, exp_count);
      end
    end
    n_checks++;
    if (n != 256) begin
      n_errors++;
      $display("FAIL reset_default_period got %0d cycles exp 256", n);
    end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_freerun();
    int s;
    int ces[$];
    int exp_q[$];
    step(0, 1, 3, 0, 0, 0);
    s = m_c;
    step(0, 0, 0, 1, 0, 0);
    n_checks++;
    if (busy !== 1'b1 || count !== 8'd3) begin
      n_errors++;
      $display("FAIL freerun_start got busy=%b count=%0d exp 1/3", busy, count);
    end
    for (int j = 0; j < 22; j++) begin
      step(0, (m_c == s + 5), 5, 0, 0, 0);
      if (ce === 1'b1) ces.push_back(m_c);
      n_checks++;
      if ({ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL freerun_model cyc=%0d got %b/%b/%0d exp %b/%b/%0d", m_c, ce, busy, count, exp_ce, exp_busy, exp_count);
      end
    end
    exp_q = '{s + 4, s + 8, s + 14, s + 20};
    n_checks++;
    if (ces != exp_q) begin
      n_errors++;
      $display("FAIL freerun_pulses got %p exp %p (rel start %0d)", ces, exp_q, s);
    end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_n0();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (ce !== 1'b1 || {ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL n0_every_cycle cyc=%0d got ce=%b busy=%b count=%0d exp ce=1", m_c, ce, busy, count);
      end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    n_checks++;
    if (ce !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL n0_stop got ce=%b busy=%b exp 0/0", ce, busy);
    end
  endtask

  task automatic test_oneshot();
    int s;
    int ces[$];
    int exp_q[$];
    step(0, 1, 2, 0, 0, 0);
    s = m_c;
    step(0, 0, 0, 1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      if (ce === 1'b1) ces.push_back(m_c);
      if (m_c == s + 4) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL oneshot_busy_clear got busy=%b exp 0", busy);
        end
      end
      n_checks++;
      if ({ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL oneshot_model cyc=%0d got %b/%b/%0d exp %b/%b/%0d", m_c, ce, busy, count, exp_ce, exp_busy, exp_count);
      end
      step(0, 0, 0, 0, 0, 0);
    end
    exp_q = '{s + 3};
    n_checks++;
    if (ces != exp_q) begin
      n_errors++;
      $display("FAIL oneshot_pulses got %p exp %p", ces, exp_q);
    end
    ces.delete();
    step(0, 0, 0, 1, 0, 1);
    s = m_c;
    step(0, 0, 0, 1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      if (ce === 1'b1) ces.push_back(m_c);
      n_checks++;
      if ({ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL oneshot_restart_model cyc=%0d got %b/%b/%0d exp %b/%b/%0d", m_c, ce, busy, count, exp_ce, exp_busy, exp_count);
      end
      step(0, 0, 0, 0, 0, 0);
    end
    exp_q = '{s + 3};
    n_checks++;
    if (ces != exp_q) begin
      n_errors++;
      $display("FAIL oneshot_restart_pulses got %p exp %p", ces, exp_q);
    end
  endtask

  task automatic test_stop();
    int nce;
    int n;
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    nce = 0;
    for (int j = 0; j < 8; j++) begin
      if (ce === 1'b1 || busy !== 1'b0) nce++;
      step(0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (nce != 0 || count !== exp_count) begin
      n_errors++;
      $display("FAIL stop_with_start got %0d active cycles count=%0d exp 0 active count=%0d", nce, count, exp_count);
    end
    step(0, 0, 0, 1, 0, 0);
    n = 0;
    while (ce !== 1'b1 && n < 10) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
    n_checks++;
    if (ce !== 1'b1 || n != 3) begin
      n_errors++;
      $display("FAIL stop_at_zero_pulse got ce=%b after %0d cycles exp 1 after 3", ce, n);
    end
    step(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({ce, busy, count} !== 10'd0) begin
      n_errors++;
      $display("FAIL stop_at_zero_after got %b/%b/%0d exp 0/0/0", ce, busy, count);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    int nce;
    step(0, 0, 0, 1, 0, 0);
    n = 0;
    while (count !== 8'd2 && n < 10) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
    step(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (count !== 8'd0 || busy !== 1'b0 || ce !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid got ce=%b busy=%b count=%0d exp 0/0/0", ce, busy, count);
    end
    nce = 0;
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 0, 0, 0);
      if (ce === 1'b1) nce++;
    end
    n_checks++;
    if (nce != 0) begin
      n_errors++;
      $display("FAIL rst_mid_quiet got %0d pulses exp 0", nce);
    end
  endtask

  task automatic test_bypass();
    int n;
    step(0, 1, 7, 1, 0, 0);
    n_checks++;
    if (count !== 8'd7 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL bypass_load got count=%0d busy=%b exp 7/1", count, busy);
    end
    n = 1;
    while (ce !== 1'b1 && n < 20) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_errors++;
      $display("FAIL bypass_period got %0d cycles exp 8", n);
    end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 9)),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0), bit'($urandom_range(0, 1)));
      n_checks++;
      if ({ce, busy, count} !== {exp_ce, exp_busy, exp_count}) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d got %b/%b/%0d exp %b/%b/%0d", m_c, ce, busy, count, exp_ce, exp_busy, exp_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1; div_we = 1'b0; div_in = 8'd0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    test_reset();
    test_freerun();
    test_n0();
    test_oneshot();
    test_stop();
    test_rst_mid();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
